transition_sequencer: RTL
=========================

Name: transition_sequencer

Overview:
- Drives the 2-bit select of the transition-output 4:1 mux. Select values: 0 = no transition, 1/2/3 = transition patterns 1/2/3.
- On a start request it plays the enabled transitions in order 1→2→3. Each transition holds for a programmable number of frame ticks.
- When the sequence ends it returns the mux to "no transition" and pulses done.
- Sits between the game control FSM (start/abort) and the mux select input.

Parameters:
- TRANSEQ_SELECTWIDTH, 2, width of select output; must be ≥2.
- TRANSEQ_HOLDWIDTH, 8, width of hold-count input and internal tick counter.

Ports:
- SC_TRANSEQ_CLOCK_50  in  1  system clock, all state on rising edge.
- SC_TRANSEQ_RESET_InLow  in  1  asynchronous, active-low reset.
- SC_TRANSEQ_start_In  in  1  start request, sampled only in IDLE, active high.
- SC_TRANSEQ_abort_In  in  1  abort request, active high.
- SC_TRANSEQ_tick_In  in  1  one-cycle frame strobe; advances the hold counter.
- SC_TRANSEQ_mask_InBUS  in  3  enabled transitions, bit0=T1, bit1=T2, bit2=T3; latched at start.
- SC_TRANSEQ_hold_InBUS  in  TRANSEQ_HOLDWIDTH  ticks per transition; latched at start.
- SC_TRANSEQ_select_OutBUS  out  TRANSEQ_SELECTWIDTH  mux select.
- SC_TRANSEQ_busy_Out  out  1  high in T1/T2/T3/DONE.
- SC_TRANSEQ_done_Out  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, RESET_InLow=0): state=IDLE, select=0, busy=0, done=0, counter=0, latched mask/hold=0. Outputs hold these values until the first edge after deassertion.
- Outputs decode combinationally from the state register. select: IDLE=0, T1=1, T2=2, T3=3, DONE=0. busy=1 in T1/T2/T3/DONE. done=1 only in DONE.
- States: IDLE, T1, T2, T3, DONE.
- IDLE:
  - start=1 and abort=0 at edge k → latch mask and hold.
  - Next state = lowest enabled stage; if mask=000 → DONE.
  - The new select value is visible right after edge k (latency 1 edge).
  - start=1 together with abort=1 → stay IDLE.
- Stage entry: counter loads eff_hold-1, where eff_hold = latched hold, or 1 if latched hold=0.
- In a stage, tick=1 with counter>0 → counter decrements.
- In a stage, tick=1 with counter=0 → go to the next enabled higher stage (counter reloads) or, if none, to DONE. Each stage therefore spans exactly eff_hold ticks.
- Ticks arriving in IDLE or DONE are ignored.
- DONE: lasts exactly one cycle, then → IDLE. No DONE→stage path.
- start while busy: ignored. It is not queued, and mask/hold are not re-latched.
- abort=1 in T1/T2/T3/DONE → IDLE at the next edge: select=0, no done pulse, counter cleared.
- abort and tick in the same cycle: abort wins.
- Changes on mask_InBUS/hold_InBUS while busy have no effect.
- Counter never wraps: it decrements only when >0.
- Maximum hold: 2^TRANSEQ_HOLDWIDTH-1 ticks.
- Reset asserted mid-sequence: IDLE immediately (asynchronous), no done pulse.

Test Plan:
1. Reset released; start=1 for 1 cycle, mask=111, hold=2, tick every 4 clocks → select sequence 1 (2 ticks), 2 (2 ticks), 3 (2 ticks), then 0. done=1 for exactly 1 cycle after the 6th tick; busy=1 from the start edge through DONE.
2. mask=101, hold=3 → select goes 1 (3 ticks) → 3 (3 ticks) → 0; value 2 never appears. mask=000 → DONE the cycle after start (select stays 0), done pulse, then IDLE.
3. hold=0, mask=010 → select=2 for exactly 1 tick, then done. Ticks applied during IDLE beforehand do not change the state.
4. In T2 with counter=1: assert abort together with tick → next edge IDLE, select=0, done never pulses, busy=0.
5. During T1, pulse start with mask=100, hold=9 → sequence continues with the original mask/hold; no restart.
6. Pull RESET_InLow low asynchronously mid-T3 (between clock edges) → select=0 and busy=0 immediately. After release, a new start operates normally from IDLE.

Source files
------------

// File: rtl/transition_sequencer.sv
// Transition sequencer: plays the enabled transition patterns 1->2->3 on the mux select,
// holding each one for a latched number of frame ticks, then pulses done and returns to idle.
module transition_sequencer #(
    parameter int TRANSEQ_SELECTWIDTH = 2,
    parameter int TRANSEQ_HOLDWIDTH   = 8
) (
    input  logic                           SC_TRANSEQ_CLOCK_50,
    input  logic                           SC_TRANSEQ_RESET_InLow,
    input  logic                           SC_TRANSEQ_start_In,
    input  logic                           SC_TRANSEQ_abort_In,
    input  logic                           SC_TRANSEQ_tick_In,
    input  logic [2:0]                     SC_TRANSEQ_mask_InBUS,
    input  logic [TRANSEQ_HOLDWIDTH-1:0]   SC_TRANSEQ_hold_InBUS,
    output logic [TRANSEQ_SELECTWIDTH-1:0] SC_TRANSEQ_select_OutBUS,
    output logic                           SC_TRANSEQ_busy_Out,
    output logic                           SC_TRANSEQ_done_Out
);

    localparam int HW = TRANSEQ_HOLDWIDTH;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] cnt_q, cnt_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [2:0]    mask_q, mask_d;
    logic [1:0]    sel_code;

    // First enabled stage strictly after stage index 'after' (0 = from idle).
    function automatic state_t next_stage(input logic [2:0] mask, input logic [1:0] after);
        state_t ns;
        if (after < 2'd1 && mask[0])      ns = ST_T1;
        else if (after < 2'd2 && mask[1]) ns = ST_T2;
        else if (after < 2'd3 && mask[2]) ns = ST_T3;
        else                              ns = ST_DONE;
        return ns;
    endfunction

    // A hold of zero is treated as one tick, so the reload never underflows.
    function automatic logic [HW-1:0] reload(input logic [HW-1:0] hold);
        return (hold == '0) ? '0 : hold - HW'(1);
    endfunction

    always_ff @(posedge SC_TRANSEQ_CLOCK_50 or negedge SC_TRANSEQ_RESET_InLow) begin
        if (!SC_TRANSEQ_RESET_InLow) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            mask_q  <= mask_d;
        end
    end

    always_comb begin
        state_t nxt;
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        mask_d  = mask_q;
        nxt     = ST_DONE;
        case (state_q)
            ST_IDLE: begin
                if (SC_TRANSEQ_start_In && !SC_TRANSEQ_abort_In) begin
                    mask_d  = SC_TRANSEQ_mask_InBUS;
                    hold_d  = SC_TRANSEQ_hold_InBUS;
                    nxt     = next_stage(SC_TRANSEQ_mask_InBUS, 2'd0);
                    state_d = nxt;
                    cnt_d   = (nxt == ST_DONE) ? '0 : reload(SC_TRANSEQ_hold_InBUS);
                end
            end
            ST_T1, ST_T2, ST_T3: begin
                if (SC_TRANSEQ_abort_In) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (SC_TRANSEQ_tick_In) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - HW'(1);
                    end else begin
                        nxt     = next_stage(mask_q, state_q[1:0]);
                        state_d = nxt;
                        cnt_d   = (nxt == ST_DONE) ? '0 : reload(hold_q);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        sel_code            = 2'd0;
        SC_TRANSEQ_busy_Out = 1'b0;
        SC_TRANSEQ_done_Out = 1'b0;
        case (state_q)
            ST_T1: begin
                sel_code            = 2'd1;
                SC_TRANSEQ_busy_Out = 1'b1;
            end
            ST_T2: begin
                sel_code            = 2'd2;
                SC_TRANSEQ_busy_Out = 1'b1;
            end
            ST_T3: begin
                sel_code            = 2'd3;
                SC_TRANSEQ_busy_Out = 1'b1;
            end
            ST_DONE: begin
                SC_TRANSEQ_busy_Out = 1'b1;
                SC_TRANSEQ_done_Out = 1'b1;
            end
            default: ;
        endcase
    end

    assign SC_TRANSEQ_select_OutBUS = TRANSEQ_SELECTWIDTH'(sel_code);

endmodule
